// File: rtl/playfield_renderer.sv
// Tetris playfield pixel stage: scan position -> board RAM address -> 8x8 block
// pattern -> shadow-palette colour, with a post-level-up flash overlay.
module playfield_renderer #(
  parameter int BOARD_X0     = 240,
  parameter int BOARD_Y0     = 80,
  parameter int COLS         = 10,
  parameter int ROWS         = 20,
  parameter int FLASH_FRAMES = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DRAW_X,
  input  logic [9:0]  DRAW_Y,
  input  logic        BLANK_N,
  input  logic        FRAME_START,
  input  logic        LEVEL_UP,
  input  logic [11:0] COLOR_0,
  input  logic [11:0] COLOR_1,
  input  logic [11:0] COLOR_2,
  input  logic [11:0] COLOR_3,
  output logic [7:0]  CELL_ADDR,
  input  logic [1:0]  CELL_DATA,
  output logic [11:0] RGB,
  output logic        BLANK_N_OUT,
  output logic        FLASHING
);

  localparam logic signed [11:0] ORG_X = 12'(BOARD_X0);
  localparam logic signed [11:0] ORG_Y = 12'(BOARD_Y0);
  localparam logic signed [11:0] PIX_W = 12'(8 * COLS);
  localparam logic signed [11:0] PIX_H = 12'(8 * ROWS);

  logic signed [11:0] dx, dy;
  logic               inb;
  logic [7:0]         col, row;

  logic               vld_p0, inb_p0;
  logic [2:0]         u_p0, v_p0;
  logic               vld_p1, inb_p1;
  logic [2:0]         u_p1, v_p1;

  logic [11:0]        shadow_0, shadow_1, shadow_2, shadow_3;
  logic [5:0]         flash_cnt, flash_cnt_nxt;
  logic               flash_on;
  logic [1:0]         idx_p2;
  logic [11:0]        rgb_p2;

  function automatic logic [7:0] cell_index(input logic [7:0] r, input logic [7:0] c);
    if (COLS == 10)
      return (r << 3) + (r << 1) + c;
    return r * 8'(COLS) + c;
  endfunction

  // Block pattern: 2 = right/bottom gap, 3 = highlight, 0/1 = body shades.
  function automatic logic [1:0] cell_idx(input logic [1:0] c, input logic [2:0] u,
                                          input logic [2:0] v);
    logic corner, ring;
    corner = (u == 3'd0) && (v == 3'd0);
    ring   = (u == 3'd0) || (u == 3'd6) || (v == 3'd0) || (v == 3'd6);
    if (u == 3'd7 || v == 3'd7) return 2'd2;
    case (c)
      2'd1:    return corner ? 2'd3 : 2'd0;
      2'd2:    return corner ? 2'd3 : 2'd1;
      2'd3:    return ring ? 2'd0 : 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Saturating frame countdown; a level-up load takes priority over a tick.
  function automatic logic [5:0] flash_step(input logic [5:0] cnt, input logic load,
                                            input logic tick);
    if (load) return 6'(FLASH_FRAMES);
    if (tick && cnt != 6'd0) return cnt - 6'd1;
    return cnt;
  endfunction

  assign dx  = $signed({2'b00, DRAW_X}) - ORG_X;
  assign dy  = $signed({2'b00, DRAW_Y}) - ORG_Y;
  assign inb = (dx >= 12'sd0) && (dx < PIX_W) && (dy >= 12'sd0) && (dy < PIX_H);
  assign col = {3'b000, dx[7:3]};
  assign row = {2'b00, dy[8:3]};

  // Stage 0: board hit test and RAM address
  always_ff @(posedge Clk) begin
    if (Reset) begin
      CELL_ADDR <= 8'd0;
      inb_p0    <= 1'b0;
      vld_p0    <= 1'b0;
    end else begin
      CELL_ADDR <= inb ? cell_index(row, col) : 8'd0;
      inb_p0    <= inb;
      vld_p0    <= BLANK_N;
    end
  end

  always_ff @(posedge Clk) begin
    u_p0 <= dx[2:0];
    v_p0 <= dy[2:0];
  end

  // Stage 1: wait for the registered RAM read
  always_ff @(posedge Clk) begin
    if (Reset) begin
      inb_p1 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      inb_p1 <= inb_p0;
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge Clk) begin
    u_p1 <= u_p0;
    v_p1 <= v_p0;
  end

  // Stage 2: pattern expansion and colour resolve
  assign flash_on = (flash_cnt != 6'd0) && flash_cnt[0];
  assign idx_p2   = cell_idx(CELL_DATA, u_p1, v_p1);

  always_comb begin
    rgb_p2 = 12'h000;
    if (vld_p1 && inb_p1 && CELL_DATA != 2'd0) begin
      if (flash_on) rgb_p2 = shadow_3;
      else begin
        case (idx_p2)
          2'd0:    rgb_p2 = shadow_0;
          2'd1:    rgb_p2 = shadow_1;
          2'd2:    rgb_p2 = shadow_2;
          default: rgb_p2 = shadow_3;
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      RGB         <= 12'h000;
      BLANK_N_OUT <= 1'b0;
    end else begin
      RGB         <= rgb_p2;
      BLANK_N_OUT <= vld_p1;
    end
  end

  // Frame-rate state: shadow palette and flash countdown
  assign flash_cnt_nxt = flash_step(flash_cnt, LEVEL_UP, FRAME_START);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      flash_cnt <= 6'd0;
      FLASHING  <= 1'b0;
    end else begin
      flash_cnt <= flash_cnt_nxt;
      FLASHING  <= (flash_cnt_nxt != 6'd0);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      shadow_0 <= 12'h000;
      shadow_1 <= 12'h000;
      shadow_2 <= 12'h000;
      shadow_3 <= 12'h000;
    end else if (FRAME_START) begin
      shadow_0 <= COLOR_0;
      shadow_1 <= COLOR_1;
      shadow_2 <= COLOR_2;
      shadow_3 <= COLOR_3;
    end
  end

endmodule

// File: tb/tb_playfield_renderer.sv
// Directed bench for playfield_renderer: palette, patterns, board edges,
// shadow capture, flash countdown, blanking and reset behaviour.
module tb_playfield_renderer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DRAW_X, DRAW_Y;
  logic        BLANK_N, FRAME_START, LEVEL_UP;
  logic [11:0] COLOR_0, COLOR_1, COLOR_2, COLOR_3;
  logic [7:0]  CELL_ADDR;
  logic [1:0]  CELL_DATA;
  logic [11:0] RGB;
  logic        BLANK_N_OUT, FLASHING;

  int          total  = 0;
  int          passed = 0;
  logic [7:0]  addr_s;

  always #5 Clk = ~Clk;

  playfield_renderer dut (
    .Clk(Clk), .Reset(Reset), .DRAW_X(DRAW_X), .DRAW_Y(DRAW_Y), .BLANK_N(BLANK_N),
    .FRAME_START(FRAME_START), .LEVEL_UP(LEVEL_UP),
    .COLOR_0(COLOR_0), .COLOR_1(COLOR_1), .COLOR_2(COLOR_2), .COLOR_3(COLOR_3),
    .CELL_ADDR(CELL_ADDR), .CELL_DATA(CELL_DATA), .RGB(RGB),
    .BLANK_N_OUT(BLANK_N_OUT), .FLASHING(FLASHING)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Hold a pixel steady long enough to cover the full pipeline depth.
  task automatic scan(input int x, input int y, input logic [1:0] c, input logic bn);
    @(negedge Clk);
    DRAW_X = 10'(x); DRAW_Y = 10'(y); CELL_DATA = c; BLANK_N = bn;
    @(posedge Clk);
    @(negedge Clk);
    addr_s = CELL_ADDR;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic frame();
    @(negedge Clk);
    FRAME_START = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    FRAME_START = 1'b0;
  endtask

  task automatic set_colors(input logic [11:0] a, b, c, d);
    @(negedge Clk);
    COLOR_0 = a; COLOR_1 = b; COLOR_2 = c; COLOR_3 = d;
  endtask

  initial begin
    Reset = 1'b1; DRAW_X = '0; DRAW_Y = '0; BLANK_N = 1'b0; FRAME_START = 1'b0;
    LEVEL_UP = 1'b0; CELL_DATA = 2'd0;
    COLOR_0 = '0; COLOR_1 = '0; COLOR_2 = '0; COLOR_3 = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_rgb", RGB, 12'h000);
    chk("rst_blank", BLANK_N_OUT, 12'h0);
    chk("rst_addr", CELL_ADDR, 12'h0);
    chk("rst_flash", FLASHING, 12'h0);
    Reset = 1'b0;

    set_colors(12'h5df, 12'h06f, 12'h000, 12'hfff);
    frame();

    scan(240, 80, 2'd1, 1'b1);
    chk("c1_corner", RGB, 12'hfff);
    chk("c1_blank", BLANK_N_OUT, 12'h1);
    chk("c1_addr", addr_s, 12'h0);
    scan(241, 80, 2'd1, 1'b1);  chk("c1_body", RGB, 12'h5df);
    scan(247, 80, 2'd1, 1'b1);  chk("c1_gap", RGB, 12'h000);
    scan(241, 81, 2'd2, 1'b1);  chk("c2_body", RGB, 12'h06f);

    scan(319, 239, 2'd1, 1'b1); chk("last_addr", addr_s, 12'd199);
    scan(319, 100, 2'd1, 1'b1); chk("right_col_addr", addr_s, 12'd29);
    scan(241, 238, 2'd1, 1'b1);
    chk("bottom_row_rgb", RGB, 12'h5df);
    chk("bottom_row_addr", addr_s, 12'd190);
    scan(320, 100, 2'd1, 1'b1);
    chk("right_out_rgb", RGB, 12'h000);
    chk("right_out_addr", addr_s, 12'h0);
    scan(239, 100, 2'd1, 1'b1);
    chk("left_out_rgb", RGB, 12'h000);
    chk("left_out_addr", addr_s, 12'h0);
    scan(241, 240, 2'd1, 1'b1);
    chk("bottom_out_rgb", RGB, 12'h000);
    chk("bottom_out_addr", addr_s, 12'h0);

    scan(243, 83, 2'd3, 1'b1);  chk("c3_center", RGB, 12'hfff);
    scan(240, 83, 2'd3, 1'b1);  chk("c3_ring0", RGB, 12'h5df);
    scan(246, 83, 2'd3, 1'b1);  chk("c3_ring6", RGB, 12'h5df);
    scan(247, 83, 2'd3, 1'b1);  chk("c3_gap", RGB, 12'h000);
    scan(242, 82, 2'd2, 1'b1);  chk("c2_22", RGB, 12'h06f);
    scan(243, 83, 2'd0, 1'b1);  chk("c0_empty", RGB, 12'h000);

    set_colors(12'h123, 12'h456, 12'h789, 12'habc);
    scan(240, 80, 2'd1, 1'b1);  chk("midframe_old3", RGB, 12'hfff);
    scan(247, 80, 2'd1, 1'b1);  chk("midframe_old2", RGB, 12'h000);
    frame();
    scan(240, 80, 2'd1, 1'b1);  chk("newframe_3", RGB, 12'habc);
    scan(247, 80, 2'd1, 1'b1);  chk("newframe_2", RGB, 12'h789);
    scan(241, 80, 2'd1, 1'b1);  chk("newframe_0", RGB, 12'h123);

    @(negedge Clk);
    LEVEL_UP = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    LEVEL_UP = 1'b0;
    chk("lvl_flashing", FLASHING, 12'h1);
    scan(241, 80, 2'd1, 1'b1);  chk("flash16_body", RGB, 12'h123);
    for (int i = 1; i <= 16; i++) begin
      frame();
      chk($sformatf("flashing_%0d", i), FLASHING, (i < 16) ? 12'h1 : 12'h0);
      scan(241, 80, 2'd1, 1'b1);
      chk($sformatf("flash_rgb_%0d", i), RGB, ((16 - i) % 2 == 1) ? 12'habc : 12'h123);
    end
    frame();
    chk("flash_saturate", FLASHING, 12'h0);

    @(negedge Clk);
    LEVEL_UP = 1'b1; FRAME_START = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    LEVEL_UP = 1'b0; FRAME_START = 1'b0;
    chk("both_flashing", FLASHING, 12'h1);
    scan(241, 80, 2'd1, 1'b1);  chk("both_load_wins", RGB, 12'h123);
    frame();
    scan(247, 80, 2'd1, 1'b1);  chk("flash_gap", RGB, 12'habc);
    scan(241, 80, 2'd2, 1'b1);  chk("flash_c2", RGB, 12'habc);
    scan(243, 83, 2'd0, 1'b1);  chk("flash_empty", RGB, 12'h000);

    scan(240, 80, 2'd1, 1'b0);
    chk("blank_rgb", RGB, 12'h000);
    chk("blank_out", BLANK_N_OUT, 12'h0);

    scan(240, 80, 2'd1, 1'b1);  chk("pre_reset_rgb", RGB, 12'habc);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("midrst_rgb", RGB, 12'h000);
    chk("midrst_blank", BLANK_N_OUT, 12'h0);
    chk("midrst_addr", CELL_ADDR, 12'h0);
    chk("midrst_flash", FLASHING, 12'h0);
    Reset = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("post_rst_blank1", BLANK_N_OUT, 12'h0);
    chk("post_rst_rgb1", RGB, 12'h000);
    @(posedge Clk);
    @(negedge Clk);
    chk("post_rst_blank2", BLANK_N_OUT, 12'h0);
    @(posedge Clk);
    @(negedge Clk);
    chk("post_rst_blank3", BLANK_N_OUT, 12'h1);
    frame();
    chk("post_rst_noflash", FLASHING, 12'h0);
    scan(241, 80, 2'd1, 1'b1);  chk("post_rst_body", RGB, 12'h123);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
